// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider controller: FSM states,
// the smallest legal divisor and the high-phase length helper.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    // Divisors below this are rejected with cfg_err.
    localparam int MIN_DIV = 2;

    // Number of clk cycles the divided clock stays high: ceil(n/2).
    // Computed one bit wider than the operand so n = all-ones cannot overflow.
    // Divisors up to 32 bits are supported; narrower ones are zero-extended.
    function automatic logic [32:0] high_phase_len(input logic [31:0] n);
        return ({1'b0, n} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/clock_divider_ctrl_div_counter.sv
// Period counter for the clock divider. Counts 0..div-1 while running,
// flags the terminal count, and produces registered clk_out/tick that are
// aligned with the counter value of the same cycle.
module div_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_i,       // divisor in force this cycle
    input  logic [WIDTH-1:0] div_next_i,  // divisor in force next cycle
    input  logic             run_i,       // block is running next cycle
    input  logic             restart_i,   // next cycle is the first of a fresh run
    output logic             terminal_o,  // counter is at div-1 this cycle
    output logic             clk_out_o,
    output logic             tick_o
);
    import clock_divider_pkg::*;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             clk_out_q;
    logic             tick_q;
    logic [32:0]      half_len;

    // div_i is always >= 2, so div_i-1 never underflows.
    assign terminal_o = (cnt_q == div_i - WIDTH'(1));

    // The output decode uses the divisor of the *next* cycle so a new
    // divisor shapes its very first period correctly.
    assign half_len = high_phase_len(32'(div_next_i));

    // Next counter value: hold at 0 when stopped or starting, wrap at terminal.
    always_comb begin
        cnt_d = '0;
        if (run_i && !restart_i && !terminal_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter and registered output decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= run_i && (33'(cnt_d) < half_len);
            tick_q    <= run_i && (cnt_d == div_next_i - WIDTH'(1));
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run-time clock divider controller: start/stop sequencing that never
// truncates a period, and a load/ack divisor handshake whose new value only
// takes effect on a period boundary (or immediately while idle).
module clock_divider_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             div_ack,
    output logic             cfg_err,
    output logic             pending,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);
    import clock_divider_pkg::*;

    state_e           state_q;
    logic             running_q;
    logic [WIDTH-1:0] div_q,  div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             err_q;

    logic is_idle;
    logic load_valid;
    logic terminal;
    logic stop_now;
    logic run_next;

    assign is_idle    = (state_q == ST_IDLE);
    assign load_valid = div_load && (div_value >= WIDTH'(MIN_DIV));
    // Stop only at the end of a period with enable low at that edge; a low
    // enable sampled exactly on the last cycle ends the current period there.
    assign stop_now   = !is_idle && terminal && !enable;
    assign run_next   = is_idle ? enable : !stop_now;

    // Divisor / pending / ack next-state. While idle a request (fresh or
    // left over from the last period) is applied at once; while running it
    // is parked and swapped in at the period-end edge. A load sampled on
    // that same edge is parked for the following boundary.
    always_comb begin
        div_d     = div_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (is_idle) begin
            pending_d = 1'b0;
            if (load_valid) begin
                div_d = div_value;
                ack_d = 1'b1;
            end else if (pending_q) begin
                div_d = pend_q;
                ack_d = 1'b1;
            end
        end else begin
            if (terminal && pending_q) begin
                div_d     = pend_q;
                ack_d     = 1'b1;
                pending_d = 1'b0;
            end
            if (load_valid) begin
                pend_d    = div_value;
                pending_d = 1'b1;
            end
        end
    end

    // Run/stop FSM with a registered running flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (terminal && !enable) state_q <= ST_IDLE;
                    else if (!enable)        state_q <= ST_STOPPING;
                end
                ST_STOPPING: begin
                    if (enable)        state_q <= ST_RUN;
                    else if (terminal) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            running_q <= run_next;
        end
    end

    // Divisor, parked request and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= WIDTH'(DEFAULT_DIV);
            pend_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            err_q     <= div_load && !load_valid;
        end
    end

    div_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .div_i      (div_q),
        .div_next_i (div_d),
        .run_i      (run_next),
        .restart_i  (is_idle),
        .terminal_o (terminal),
        .clk_out_o  (clk_out),
        .tick_o     (tick)
    );

    assign div_ack = ack_q;
    assign cfg_err = err_q;
    assign pending = pending_q;
    assign running = running_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the divider.
module tb_clock_divider_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [W-1:0] div_value;
    logic         div_load;
    logic         div_ack, cfg_err, pending, clk_out, tick, running;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_run, m_pending, m_ack, m_err, m_clk, m_tick;
    int m_cnt, m_div, m_pend;

    always #5 clk = ~clk;

    clock_divider_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .div_value (div_value),
        .div_load  (div_load),
        .div_ack   (div_ack),
        .cfg_err   (cfg_err),
        .pending   (pending),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_div = 4; m_pending = 0; m_pend = 0;
        m_ack = 0; m_err = 0; m_clk = 0; m_tick = 0;
    endtask

    // One clock edge of the divider, expressed as period arithmetic.
    task automatic model_step();
        int v;
        bit ok, period_end;
        v = int'(div_value);
        ok = div_load && (v >= 2);
        m_err = div_load && !ok;
        m_ack = 0;
        if (!m_run) begin
            if (ok) begin
                m_div = v; m_ack = 1;
            end else if (m_pending) begin
                m_div = m_pend; m_ack = 1;
            end
            m_pending = 0;
            m_cnt = 0;
            m_run = enable;
        end else begin
            period_end = (m_cnt == m_div - 1);
            if (period_end && m_pending) begin
                m_div = m_pend; m_pending = 0; m_ack = 1;
            end
            if (ok) begin
                m_pend = v; m_pending = 1;
            end
            if (period_end) begin
                m_cnt = 0;
                if (!enable) m_run = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_clk  = m_run && (m_cnt < (m_div + 1) / 2);
        m_tick = m_run && (m_cnt == m_div - 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Advance until the DUT shows tick (last cycle of a period), bounded.
    task automatic wait_tick(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (tick === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_wait_tick got=no_tick want=tick_within_40", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1; enable = 0; div_load = 0; div_value = '0;
        model_reset();
        #2;
        checks++;
        if ({div_ack, cfg_err, pending, clk_out, tick, running} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {div_ack, cfg_err, pending, clk_out, tick, running});
        end
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({running, clk_out, tick} !== 3'b000) begin
                errors++;
                $display("FAIL idle_hold[%0d] got=%b want=000", i, {running, clk_out, tick});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_default_run();
        logic [2:0] exp;
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            exp = {1'b1, ((i % 4) < 2) ? 1'b1 : 1'b0, ((i % 4) == 3) ? 1'b1 : 1'b0};
            checks++;
            if ({running, clk_out, tick} !== exp) begin
                errors++;
                $display("FAIL div4_run[%0d] got=%b want=%b", i, {running, clk_out, tick}, exp);
            end
        end
        $display("test_default_run done");
    endtask

    task automatic test_bad_load();
        wait_tick("bad_load");
        cycle();                                 // cnt=0
        div_load = 1; div_value = 16'd1;
        cycle();                                 // cnt=1
        checks++;
        if ({cfg_err, div_ack, pending} !== 3'b100) begin
            errors++;
            $display("FAIL bad_load_1 got=%b want=100", {cfg_err, div_ack, pending});
        end
        div_value = 16'd0;
        cycle();                                 // cnt=2
        checks++;
        if ({cfg_err, div_ack, pending} !== 3'b100) begin
            errors++;
            $display("FAIL bad_load_0 got=%b want=100", {cfg_err, div_ack, pending});
        end
        div_load = 0;
        for (int k = 0; k < 5; k++) begin        // cnt=3,0,1,2,3
            cycle();
            checks++;
            if ({cfg_err, div_ack, tick} !== {2'b00, (k == 0 || k == 4) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL bad_load_period[%0d] got=%b want_tick=%0d", k,
                         {cfg_err, div_ack, tick}, (k == 0 || k == 4));
            end
        end
        $display("test_bad_load done");
    endtask

    task automatic test_stop_restart();
        bit         en_seq  [10];
        logic [2:0] exp_seq [10];
        en_seq  = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 1};
        exp_seq = '{3'b100, 3'b101, 3'b000, 3'b000, 3'b110,
                    3'b110, 3'b100, 3'b101, 3'b110, 3'b110};
        wait_tick("stop");
        cycle();                                 // cnt=0
        cycle();                                 // cnt=1
        for (int i = 0; i < 10; i++) begin
            enable = en_seq[i];
            cycle();
            checks++;
            if ({running, clk_out, tick} !== exp_seq[i]) begin
                errors++;
                $display("FAIL stop_seq[%0d] got=%b want=%b", i, {running, clk_out, tick}, exp_seq[i]);
            end
        end
        $display("test_stop_restart done");
    endtask

    task automatic test_reconfig();
        logic [3:0] exp;
        wait_tick("reconfig");
        cycle();                                 // cnt=0
        cycle();                                 // cnt=1
        div_load = 1; div_value = 16'd6;
        cycle();                                 // cnt=2
        div_load = 0;
        checks++;
        if ({pending, div_ack} !== 2'b10) begin
            errors++;
            $display("FAIL reconfig_pend_cnt2 got=%b want=10", {pending, div_ack});
        end
        cycle();                                 // cnt=3
        checks++;
        if ({pending, div_ack, tick} !== 3'b101) begin
            errors++;
            $display("FAIL reconfig_pend_cnt3 got=%b want=101", {pending, div_ack, tick});
        end
        for (int k = 0; k < 12; k++) begin
            cycle();
            exp = {(k == 0) ? 1'b1 : 1'b0, ((k % 6) < 3) ? 1'b1 : 1'b0,
                   ((k % 6) == 5) ? 1'b1 : 1'b0, 1'b0};
            checks++;
            if ({div_ack, clk_out, tick, pending} !== exp) begin
                errors++;
                $display("FAIL div6_period[%0d] got=%b want=%b", k, {div_ack, clk_out, tick, pending}, exp);
            end
        end
        $display("test_reconfig done");
    endtask

    task automatic test_double_load();
        bit seen;
        logic [3:0] exp;
        int j;
        div_load = 1; div_value = 16'd8;
        cycle();
        div_load = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (div_ack === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL div8_ack got=no_ack want=ack_within_20");
        end
        // now at cnt=0 of an N=8 period
        div_load = 1; div_value = 16'd5;
        cycle();                                 // cnt=1
        div_load = 0;
        cycle();                                 // cnt=2
        div_load = 1; div_value = 16'd7;
        cycle();                                 // cnt=3
        div_load = 0;
        for (int k = 0; k < 18; k++) begin
            cycle();
            if (k < 4) begin
                exp = {1'b0, 1'b0, (k == 3) ? 1'b1 : 1'b0, 1'b1};
            end else begin
                j = (k - 4) % 7;
                exp = {(k == 4) ? 1'b1 : 1'b0, (j < 4) ? 1'b1 : 1'b0, (j == 6) ? 1'b1 : 1'b0, 1'b0};
            end
            checks++;
            if ({div_ack, clk_out, tick, pending} !== exp) begin
                errors++;
                $display("FAIL double_load[%0d] got=%b want=%b", k, {div_ack, clk_out, tick, pending}, exp);
            end
        end
        $display("test_double_load done");
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        div_load = 1; div_value = 16'd9;
        cycle();
        div_load = 0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending got=%b want=1", pending);
        end
        #3;
        rst = 1;
        #1;
        checks++;
        if ({div_ack, cfg_err, pending, clk_out, tick, running} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got=%b want=000000",
                     {div_ack, cfg_err, pending, clk_out, tick, running});
        end
        enable = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        enable = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            exp = {((k % 4) < 2) ? 1'b1 : 1'b0, ((k % 4) == 3) ? 1'b1 : 1'b0, 2'b00};
            checks++;
            if ({clk_out, tick, pending, div_ack} !== exp) begin
                errors++;
                $display("FAIL post_reset_div4[%0d] got=%b want=%b", k, {clk_out, tick, pending, div_ack}, exp);
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic [5:0] exp;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            div_load  = ($urandom_range(0, 4) == 0);
            div_value = W'($urandom_range(0, 12));
            cycle();
            exp = {m_ack, m_err, m_pending, m_clk, m_tick, m_run};
            checks++;
            if ({div_ack, cfg_err, pending, clk_out, tick, running} !== exp) begin
                errors++;
                $display("FAIL random[%0d] got=%b want=%b (ack,err,pend,clk,tick,run)", i,
                         {div_ack, cfg_err, pending, clk_out, tick, running}, exp);
            end
        end
        div_load = 0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_bad_load();
        test_stop_restart();
        test_reconfig();
        test_double_load();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
